// File: rtl/out_port_bcd_display.sv
// BCD display driver for one memory-mapped output port.
// Converts the low bits of the port value with a serial double-dabble engine.
module out_port_bcd_display #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [31:0]           value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  busy,
    output logic                  overflow
);

    localparam int CW = $clog2(IN_WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    if (pow10(DIGITS) <= ((64'd1 << IN_WIDTH) - 64'd1)) begin : g_bad_digits
        $error("DIGITS too small for IN_WIDTH");
    end

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t                r_state, w_state_n;
    logic [31:0]           r_src, w_src_n;
    logic [IN_WIDTH-1:0]   r_shift, w_shift_n;
    logic [4*DIGITS-1:0]   r_acc, w_acc_n;
    logic [4*DIGITS-1:0]   r_bcd, w_bcd_n;
    logic                  r_busy, w_busy_n;
    logic                  r_ovf, w_ovf_n;
    logic [CW-1:0]         r_cnt, w_cnt_n;

    logic [4*DIGITS-1:0]   w_corr;
    logic [4*DIGITS-1:0]   w_step_acc;
    logic [IN_WIDTH-1:0]   w_step_shift;
    logic [7*DIGITS-1:0]   w_seg;

    // Add-3 correction per nibble, no carry between nibbles.
    always_comb begin
        w_corr = r_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5) begin
                w_corr[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_step_acc   = {w_corr[4*DIGITS-2:0], r_shift[IN_WIDTH-1]};
    assign w_step_shift = r_shift << 1;

    always_comb begin
        w_state_n = r_state;
        w_src_n   = r_src;
        w_shift_n = r_shift;
        w_acc_n   = r_acc;
        w_bcd_n   = r_bcd;
        w_busy_n  = r_busy;
        w_ovf_n   = r_ovf;
        w_cnt_n   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (value != r_src) begin
                    w_src_n   = value;
                    w_shift_n = value[IN_WIDTH-1:0];
                    w_acc_n   = '0;
                    w_ovf_n   = |value[31:IN_WIDTH];
                    w_busy_n  = 1'b1;
                    w_cnt_n   = '0;
                    w_state_n = CONV;
                end
            end
            CONV: begin
                w_acc_n   = w_step_acc;
                w_shift_n = w_step_shift;
                w_cnt_n   = r_cnt + 1'b1;
                if (r_cnt == CW'(IN_WIDTH - 1)) begin
                    w_bcd_n   = w_step_acc;
                    w_busy_n  = 1'b0;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_shift <= '0;
            r_acc   <= '0;
            r_bcd   <= '0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_src   <= w_src_n;
            r_shift <= w_shift_n;
            r_acc   <= w_acc_n;
            r_bcd   <= w_bcd_n;
            r_busy  <= w_busy_n;
            r_ovf   <= w_ovf_n;
            r_cnt   <= w_cnt_n;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Walk from the top digit; blanking stops at the first nonzero digit.
    always_comb begin
        logic       lz;
        logic [3:0] nib;
        w_seg = '1;
        lz    = 1'b1;
        nib   = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib = r_bcd[4*d +: 4];
            if (BLANK_LZ && (d != 0) && lz && (nib == 4'd0)) begin
                w_seg[7*d +: 7] = 7'b1111111;
            end else begin
                lz              = 1'b0;
                w_seg[7*d +: 7] = seg7(nib);
            end
        end
    end

    assign bcd      = r_bcd;
    assign seg      = w_seg;
    assign busy     = r_busy;
    assign overflow = r_ovf;

endmodule
